// File: rtl/toss_pkg.sv
// ---------------------------------------------------------------------------
// toss_pkg
// Shared types for the coin-toss scorer: match FSM states and the encoding
// of the winner output.
// ---------------------------------------------------------------------------
package toss_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [1:0] winner_t;

  localparam winner_t WIN_NONE  = 2'b00;
  localparam winner_t WIN_HEADS = 2'b01;
  localparam winner_t WIN_TAILS = 2'b10;

endpackage : toss_pkg

// File: rtl/toss_majority.sv
// ---------------------------------------------------------------------------
// toss_majority
// Combinational majority vote over three coin bits (1 = heads).
//   toss_i  in  3  coin bits
//   maj_o   out 1  1 when at least two coins show heads
// ---------------------------------------------------------------------------
module toss_majority (
  input  logic [2:0] toss_i,
  output logic       maj_o
);

  assign maj_o = (toss_i[0] & toss_i[1]) |
                 (toss_i[0] & toss_i[2]) |
                 (toss_i[1] & toss_i[2]);

endmodule : toss_majority

// File: rtl/toss_scorer.sv
// ---------------------------------------------------------------------------
// toss_scorer
// Scores 3-coin toss words as a best-of-ROUNDS match. Each accepted sample
// is one round decided by majority; the first side to reach a majority of
// ROUNDS wins. A registered pulse marks every completed run of STREAK_LEN
// consecutive heads rounds (the run counter re-arms after each pulse).
//
// Ports
//   clk         in  1      rising-edge clock
//   rst         in  1      synchronous active-high reset
//   start       in  1      begin a new match (honoured in IDLE and DONE)
//   toss_valid  in  1      toss carries a sample this cycle
//   toss        in  3      coin bits, 1 = heads
//   busy        out 1      match in progress
//   done        out 1      match decided
//   winner      out 2      00 none, 01 heads, 10 tails
//   heads_cnt   out CNT_W  heads rounds this match
//   tails_cnt   out CNT_W  tails rounds this match
//   streak_hit  out 1      one-cycle pulse on completing a heads streak
// ---------------------------------------------------------------------------
module toss_scorer
  import toss_pkg::*;
#(
  parameter int ROUNDS     = 7,
  parameter int STREAK_LEN = 3,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             toss_valid,
  input  logic [2:0]       toss,
  output logic             busy,
  output logic             done,
  output logic [1:0]       winner,
  output logic [CNT_W-1:0] heads_cnt,
  output logic [CNT_W-1:0] tails_cnt,
  output logic             streak_hit
);

  localparam logic [CNT_W-1:0] WIN = CNT_W'((ROUNDS + 1) / 2);
  localparam int               SW  = $clog2(STREAK_LEN + 1);
  localparam logic [SW-1:0]    STREAK_MAX = SW'(STREAK_LEN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] heads_q, heads_d;
  logic [CNT_W-1:0] tails_q, tails_d;
  logic [SW-1:0]    streak_q, streak_d;
  winner_t          winner_q, winner_d;
  logic             hit_q, hit_d;

  logic             maj;
  logic             score;
  logic             clear;
  logic [CNT_W-1:0] heads_inc, tails_inc;
  logic [SW-1:0]    streak_inc;
  logic             heads_win, tails_win;

  toss_majority u_majority (
    .toss_i (toss),
    .maj_o  (maj)
  );

  // A sample only counts while playing; start only clears outside PLAY, so a
  // start in PLAY and a toss coincident with start in IDLE/DONE both drop.
  assign score      = (state_q == PLAY) && toss_valid;
  assign clear      = (state_q != PLAY) && start;
  assign heads_inc  = heads_q + CNT_W'(1);
  assign tails_inc  = tails_q + CNT_W'(1);
  assign streak_inc = streak_q + SW'(1);
  // Win is judged on the post-increment count, so the deciding toss and the
  // move to DONE happen on the same edge.
  assign heads_win  = maj  && (heads_inc == WIN);
  assign tails_win  = !maj && (tails_inc == WIN);

  // ---- state register ----
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---- next-state logic ----
  // NOTE: each always_comb assigns its outputs a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = PLAY;
      PLAY:       if (score && (heads_win || tails_win)) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // ---- output logic ----
  always_comb begin
    busy = (state_q == PLAY);
    done = (state_q == DONE);
  end

  // ---- scoring datapath ----
  always_comb begin
    heads_d  = heads_q;
    tails_d  = tails_q;
    streak_d = streak_q;
    winner_d = winner_q;
    hit_d    = 1'b0;
    if (clear) begin
      heads_d  = '0;
      tails_d  = '0;
      streak_d = '0;
      winner_d = WIN_NONE;
    end else if (score) begin
      if (maj) begin
        heads_d = heads_inc;
        // Completing a streak pulses and restarts the run so later streaks
        // in the same match are counted again.
        if (streak_inc == STREAK_MAX) begin
          hit_d    = 1'b1;
          streak_d = '0;
        end else begin
          streak_d = streak_inc;
        end
        if (heads_win) winner_d = WIN_HEADS;
      end else begin
        tails_d  = tails_inc;
        streak_d = '0;
        if (tails_win) winner_d = WIN_TAILS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      heads_q  <= '0;
      tails_q  <= '0;
      streak_q <= '0;
      winner_q <= WIN_NONE;
      hit_q    <= 1'b0;
    end else begin
      heads_q  <= heads_d;
      tails_q  <= tails_d;
      streak_q <= streak_d;
      winner_q <= winner_d;
      hit_q    <= hit_d;
    end
  end

  assign winner     = winner_q;
  assign heads_cnt  = heads_q;
  assign tails_cnt  = tails_q;
  assign streak_hit = hit_q;

endmodule : toss_scorer

// File: tb/tb_toss_scorer.sv
// ---------------------------------------------------------------------------
// tb_toss_scorer
// Directed and random stimulus for toss_scorer, compared every cycle against
// a behavioural match model kept in plain integers.
// ---------------------------------------------------------------------------
module tb_toss_scorer;

  localparam int ROUNDS     = 7;
  localparam int STREAK_LEN = 3;
  localparam int CNT_W      = 4;
  localparam int WIN        = (ROUNDS + 1) / 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             toss_valid = 1'b0;
  logic [2:0]       toss = 3'b000;
  logic             busy;
  logic             done;
  logic [1:0]       winner;
  logic [CNT_W-1:0] heads_cnt;
  logic [CNT_W-1:0] tails_cnt;
  logic             streak_hit;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 = waiting, 1 = playing, 2 = decided.
  int m_phase  = 0;
  int m_heads  = 0;
  int m_tails  = 0;
  int m_run    = 0;
  int m_winner = 0;
  int m_hit    = 0;

  toss_scorer #(
    .ROUNDS     (ROUNDS),
    .STREAK_LEN (STREAK_LEN),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .toss_valid (toss_valid),
    .toss       (toss),
    .busy       (busy),
    .done       (done),
    .winner     (winner),
    .heads_cnt  (heads_cnt),
    .tails_cnt  (tails_cnt),
    .streak_hit (streak_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the match rules, applied to the model.
  task automatic model_edge(input bit s, input bit v, input logic [2:0] t, input bit r);
    m_hit = 0;
    if (r) begin
      m_phase = 0; m_heads = 0; m_tails = 0; m_run = 0; m_winner = 0;
    end else if (m_phase != 1) begin
      if (s) begin
        m_phase = 1; m_heads = 0; m_tails = 0; m_run = 0; m_winner = 0;
      end
    end else if (v) begin
      if ($countones(t) >= 2) begin
        m_heads++;
        m_run++;
        if (m_run == STREAK_LEN) begin
          m_hit = 1;
          m_run = 0;
        end
        if (m_heads == WIN) begin
          m_phase = 2; m_winner = 1;
        end
      end else begin
        m_tails++;
        m_run = 0;
        if (m_tails == WIN) begin
          m_phase = 2; m_winner = 2;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("busy",       8'(busy),       8'(m_phase == 1));
    check("done",       8'(done),       8'(m_phase == 2));
    check("winner",     8'(winner),     8'(m_winner));
    check("heads_cnt",  8'(heads_cnt),  8'(m_heads));
    check("tails_cnt",  8'(tails_cnt),  8'(m_tails));
    check("streak_hit", 8'(streak_hit), 8'(m_hit));
  endtask

  // Drive inputs away from the edge, clock once, then sample 1 ns later.
  task automatic step(input bit s, input bit v, input logic [2:0] t, input bit r);
    @(negedge clk);
    start = s; toss_valid = v; toss = t; rst = r;
    @(posedge clk);
    model_edge(s, v, t, r);
    #1;
    compare_all();
  endtask

  initial begin
    // Reset state.
    step(0, 0, 3'b000, 1);
    step(0, 0, 3'b000, 1);
    check("reset_idle_busy", 8'(busy), 8'd0);
    step(0, 1, 3'b111, 0);
    check("idle_ignores_toss", 8'(heads_cnt), 8'd0);

    // Reset mid-PLAY after two heads.
    step(1, 0, 3'b000, 0);
    step(0, 1, 3'b111, 0);
    step(0, 1, 3'b111, 0);
    check("pre_reset_heads", 8'(heads_cnt), 8'd2);
    step(0, 0, 3'b000, 1);
    check("midplay_reset_heads", 8'(heads_cnt), 8'd0);
    check("midplay_reset_busy", 8'(busy), 8'd0);
    step(0, 1, 3'b111, 0);
    check("after_reset_toss_ignored", 8'(heads_cnt), 8'd0);

    // Heads sweep: four straight heads wins.
    step(1, 0, 3'b000, 0);
    step(0, 1, 3'b111, 0);
    step(0, 1, 3'b111, 0);
    step(0, 1, 3'b111, 0);
    check("sweep_streak_pulse", 8'(streak_hit), 8'd1);
    step(0, 1, 3'b111, 0);
    check("sweep_done", 8'(done), 8'd1);
    check("sweep_winner", 8'(winner), 8'd1);
    check("sweep_pulse_clears", 8'(streak_hit), 8'd0);
    step(0, 1, 3'b111, 0);
    check("sweep_fifth_ignored", 8'(heads_cnt), 8'd4);

    // Majority decode of mixed patterns.
    step(1, 0, 3'b000, 0);
    step(0, 1, 3'b011, 0);
    step(0, 1, 3'b100, 0);
    step(0, 1, 3'b101, 0);
    step(0, 1, 3'b000, 0);
    check("decode_heads", 8'(heads_cnt), 8'd2);
    check("decode_tails", 8'(tails_cnt), 8'd2);
    check("decode_not_done", 8'(done), 8'd0);

    // Tails win with interleave H,T,T,H,T,T.
    step(0, 0, 3'b000, 1);
    step(1, 0, 3'b000, 0);
    step(0, 1, 3'b110, 0);
    step(0, 1, 3'b001, 0);
    step(0, 1, 3'b010, 0);
    step(0, 1, 3'b111, 0);
    step(0, 1, 3'b000, 0);
    check("interleave_not_done_yet", 8'(done), 8'd0);
    step(0, 1, 3'b100, 0);
    check("interleave_tails", 8'(tails_cnt), 8'd4);
    check("interleave_heads", 8'(heads_cnt), 8'd2);
    check("interleave_winner", 8'(winner), 8'd2);
    check("interleave_done", 8'(done), 8'd1);

    // Streak re-arm across two matches, restarted from DONE.
    step(1, 0, 3'b000, 0);
    check("restart_clears_tails", 8'(tails_cnt), 8'd0);
    check("restart_clears_winner", 8'(winner), 8'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 3'b111, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 3'b111, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 3'b000, 0);
    check("rearm_first_match_tails_win", 8'(winner), 8'd2);
    step(1, 0, 3'b000, 0);
    check("rearm_counts_clear", 8'(heads_cnt), 8'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 3'b111, 0);
    check("rearm_second_pulse", 8'(streak_hit), 8'd1);

    // Control corners.
    step(1, 1, 3'b000, 0);
    check("start_in_play_no_clear", 8'(heads_cnt), 8'd3);
    check("start_in_play_scores", 8'(tails_cnt), 8'd1);
    step(0, 0, 3'b000, 1);
    step(1, 1, 3'b111, 0);
    check("start_with_toss_dropped", 8'(heads_cnt), 8'd0);
    check("start_with_toss_busy", 8'(busy), 8'd1);
    step(0, 0, 3'b000, 1);
    step(1, 0, 3'b000, 1);
    check("rst_beats_start", 8'(busy), 8'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_toss_scorer
